// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and default sizing for the data-memory arbiter that sits
// between the CPU data port, a host (loader/debug) port and a single-port
// synchronous-read data RAM.
//
// Contents:
//   DMEM_AW / DMEM_DW / DMEM_MAX_WAIT  default address width, data width and
//                                       host starvation limit
//   WAIT_CW                             width of the host wait counter
//   port_t                              which requester owns an access
//   wait_cnt_t                          host wait counter type
//   port_of()                           maps a host grant onto port_t
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DMEM_AW       = 16;
  localparam int DMEM_DW       = 16;
  localparam int DMEM_MAX_WAIT = 4;

  // Four bits cover every legal starvation limit (1..15).
  localparam int WAIT_CW = 4;

  typedef enum logic {
    PORT_CPU  = 1'b0,
    PORT_HOST = 1'b1
  } port_t;

  typedef logic [WAIT_CW-1:0] wait_cnt_t;

  // At most one port is granted per cycle, so the host grant alone tells us
  // who owns the access.
  function automatic port_t port_of(input logic h_gnt);
    return h_gnt ? PORT_HOST : PORT_CPU;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the CPU request port, the host request port and the data RAM port
// of the arbiter.
//
// Signals:
//   c_req, c_we, c_addr, c_wdata    CPU access request
//   c_gnt, stall                    CPU access accepted / CPU must hold
//   c_rvalid, c_rdata               CPU read return
//   h_req, h_we, h_addr, h_wdata    host access request
//   h_gnt, h_rvalid, h_rdata        host grant / read return
//   mem_we, mem_addr, mem_wdata     RAM command (combinational)
//   mem_rdata                       RAM read data, valid one cycle after address
//
// Modports:
//   slave   the arbiter's view
//   master  the surrounding system's view (CPU, host and RAM together)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) ();

  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          stall;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  h_req, h_we, h_addr, h_wdata,
    input  mem_rdata,
    output c_gnt, stall, c_rvalid, c_rdata,
    output h_gnt, h_rvalid, h_rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output h_req, h_we, h_addr, h_wdata,
    output mem_rdata,
    input  c_gnt, stall, c_rvalid, c_rdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_fair_sel.sv
// -----------------------------------------------------------------------------
// rr_fair_sel
// Two-requester grant logic for the data-memory arbiter. The CPU normally
// wins contention; the host counts the cycles it has been refused and is
// granted once that count reaches MAX_WAIT, so it can never be starved.
//
// Parameters:
//   MAX_WAIT  refused host cycles before a forced host grant (1..15)
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-low reset; grants are held low while asserted
//   c_req   CPU request
//   h_req   host request
//   c_gnt   CPU granted this cycle (combinational)
//   h_gnt   host granted this cycle (combinational)
// -----------------------------------------------------------------------------
module rr_fair_sel
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic c_req,
  input  logic h_req,
  output logic c_gnt,
  output logic h_gnt
);

  localparam wait_cnt_t WAIT_LIMIT = wait_cnt_t'(MAX_WAIT);

  wait_cnt_t wait_cnt;

  // Grants depend only on the current requests and the wait counter, so a
  // requester sees its grant in the same cycle it raises req. The host wins
  // when it is alone or when it has already been refused MAX_WAIT times.
  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (reset) begin
      if (h_req && (!c_req || wait_cnt == WAIT_LIMIT)) begin
        h_gnt = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end
    end
  end

  // The counter only measures an unbroken run of refused host cycles:
  // dropping the request or being served starts the run over. It stops at
  // the limit, which is also the cycle the host is forced through.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!h_req || h_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + wait_cnt_t'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port, synchronous-read data RAM between the CPU data
// port and a host (loader/debug) port. One access is accepted per cycle.
// The RAM command is steered combinationally from the granted port. Read
// data comes back one cycle later and is routed to whichever port issued
// the read.
//
// Parameters:
//   AW        address width
//   DW        data width
//   MAX_WAIT  refused host cycles before a forced host grant (1..15)
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-low reset
//   bus     dmem_arbiter_if.slave: CPU port, host port and RAM port
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  logic          c_gnt;
  logic          h_gnt;

  logic          mem_we_mux;
  logic [AW-1:0] mem_addr_mux;
  logic [DW-1:0] mem_wdata_mux;

  logic          rd_pend;
  port_t         owner;
  logic          c_ret;
  logic          h_ret;

  rr_fair_sel #(
    .MAX_WAIT (MAX_WAIT)
  ) u_sel (
    .clk   (clk),
    .reset (reset),
    .c_req (bus.c_req),
    .h_req (bus.h_req),
    .c_gnt (c_gnt),
    .h_gnt (h_gnt)
  );

  assign bus.c_gnt = c_gnt;
  assign bus.h_gnt = h_gnt;

  // A CPU that asked and was refused must freeze its PC and instruction.
  assign bus.stall = bus.c_req && !c_gnt;

  // Steer the granted port onto the RAM. With no grant the RAM sees an
  // all-zero idle command so nothing stray is written.
  always_comb begin
    mem_we_mux    = 1'b0;
    mem_addr_mux  = '0;
    mem_wdata_mux = '0;
    if (c_gnt) begin
      mem_we_mux    = bus.c_we;
      mem_addr_mux  = bus.c_addr;
      mem_wdata_mux = bus.c_wdata;
    end else if (h_gnt) begin
      mem_we_mux    = bus.h_we;
      mem_addr_mux  = bus.h_addr;
      mem_wdata_mux = bus.h_wdata;
    end
  end

  assign bus.mem_we    = mem_we_mux;
  assign bus.mem_addr  = mem_addr_mux;
  assign bus.mem_wdata = mem_wdata_mux;

  // Remember whether this cycle's accepted access was a read and who issued
  // it. The RAM returns the data next cycle, and with accepts allowed every
  // cycle a single pending slot is enough.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_pend <= 1'b0;
      owner   <= PORT_CPU;
    end else begin
      rd_pend <= (c_gnt && !bus.c_we) || (h_gnt && !bus.h_we);
      owner   <= port_of(h_gnt);
    end
  end

  // Returns are suppressed while reset is low, so a read accepted just
  // before reset never reports data.
  assign c_ret = reset && rd_pend && (owner == PORT_CPU);
  assign h_ret = reset && rd_pend && (owner == PORT_HOST);

  assign bus.c_rvalid = c_ret;
  assign bus.h_rvalid = h_ret;
  assign bus.c_rdata  = c_ret ? bus.mem_rdata : '0;
  assign bus.h_rdata  = h_ret ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. It combines a table of directed
// vectors, hand-written grant sequences for the starvation counter, and
// randomized traffic compared against a transaction-level reference model.
// The bench also models the synchronous-read data RAM.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic        rst;
    logic        c_req;
    logic        c_we;
    logic [15:0] c_addr;
    logic [15:0] c_wdata;
    logic        h_req;
    logic        h_we;
    logic [15:0] h_addr;
    logic [15:0] h_wdata;
  } in_t;

  typedef struct packed {
    logic        c_gnt;
    logic        h_gnt;
    logic        stall;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        c_rvalid;
    logic [15:0] c_rdata;
    logic        h_rvalid;
    logic [15:0] h_rdata;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t exp;
  } vec_t;

  typedef struct packed {
    port_t       port;
    logic [15:0] data;
  } ret_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data RAM: synchronous read, data valid the cycle after the address.
  logic [15:0] ram [256];
  logic        ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'(i * 7 + 3);
      ram_ready <= 1'b1;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end

  // Reference model state: memory contents, the run of refused host cycles,
  // and reads whose data is due next cycle.
  logic [15:0] ref_ram [256];
  int          lost = 0;
  ret_t        retq[$];
  out_t        model_out;

  int tests = 0;
  int fails = 0;

  vec_t vecs[$];

  function automatic in_t mkIn(input logic rst, input logic c_req, input logic c_we,
                               input logic [15:0] c_addr, input logic [15:0] c_wdata,
                               input logic h_req, input logic h_we,
                               input logic [15:0] h_addr, input logic [15:0] h_wdata);
    in_t s;
    s.rst = rst; s.c_req = c_req; s.c_we = c_we; s.c_addr = c_addr; s.c_wdata = c_wdata;
    s.h_req = h_req; s.h_we = h_we; s.h_addr = h_addr; s.h_wdata = h_wdata;
    return s;
  endfunction

  function automatic out_t mkOut(input logic cg, input logic hg, input logic st, input logic we,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic crv, input logic [15:0] crd,
                                 input logic hrv, input logic [15:0] hrd);
    out_t o;
    o.c_gnt = cg; o.h_gnt = hg; o.stall = st; o.mem_we = we;
    o.mem_addr = addr; o.mem_wdata = wdata;
    o.c_rvalid = crv; o.c_rdata = crd; o.h_rvalid = hrv; o.h_rdata = hrd;
    return o;
  endfunction

  function automatic void addVec(input in_t s, input out_t o);
    vec_t v;
    v.stim = s;
    v.exp  = o;
    vecs.push_back(v);
  endfunction

  function automatic out_t sampleOut();
    out_t o;
    o.c_gnt = bus.c_gnt; o.h_gnt = bus.h_gnt; o.stall = bus.stall; o.mem_we = bus.mem_we;
    o.mem_addr = bus.mem_addr; o.mem_wdata = bus.mem_wdata;
    o.c_rvalid = bus.c_rvalid; o.c_rdata = bus.c_rdata;
    o.h_rvalid = bus.h_rvalid; o.h_rdata = bus.h_rdata;
    return o;
  endfunction

  // Expected outputs for one cycle, from the arbitration rules: sole
  // requester wins; under contention the CPU wins unless the host has
  // already been refused MAX_WAIT times in a row.
  function automatic out_t modelExpect(input in_t s);
    out_t o;
    logic host_wins;
    o = '0;
    if (!s.rst) begin
      o.stall = s.c_req;
      return o;
    end
    host_wins = s.h_req && (!s.c_req || lost >= MAX_WAIT);
    o.h_gnt   = host_wins;
    o.c_gnt   = s.c_req && !host_wins;
    o.stall   = s.c_req && !o.c_gnt;
    if (o.c_gnt) begin
      o.mem_we = s.c_we; o.mem_addr = s.c_addr; o.mem_wdata = s.c_wdata;
    end else if (o.h_gnt) begin
      o.mem_we = s.h_we; o.mem_addr = s.h_addr; o.mem_wdata = s.h_wdata;
    end
    if (retq.size() > 0) begin
      if (retq[0].port == PORT_CPU) begin
        o.c_rvalid = 1'b1; o.c_rdata = retq[0].data;
      end else begin
        o.h_rvalid = 1'b1; o.h_rdata = retq[0].data;
      end
    end
    return o;
  endfunction

  // Advance the model across the clock edge that ends the cycle.
  task automatic modelUpdate(input in_t s, input out_t o);
    ret_t r;
    retq.delete();
    if (!s.rst) begin
      lost = 0;
      return;
    end
    if (o.mem_we) begin
      ref_ram[o.mem_addr[7:0]] = o.mem_wdata;
    end else if (o.c_gnt || o.h_gnt) begin
      r.port = o.h_gnt ? PORT_HOST : PORT_CPU;
      r.data = ref_ram[o.mem_addr[7:0]];
      retq.push_back(r);
    end
    if (s.h_req && !o.h_gnt) lost = (lost < MAX_WAIT) ? lost + 1 : MAX_WAIT;
    else                     lost = 0;
  endtask

  // Drive one cycle's inputs at the falling edge, let them settle, and
  // record the model's view of the cycle.
  task automatic applyStimulus(input in_t s);
    @(negedge clk);
    reset       = s.rst;
    bus.c_req   = s.c_req;
    bus.c_we    = s.c_we;
    bus.c_addr  = s.c_addr;
    bus.c_wdata = s.c_wdata;
    bus.h_req   = s.h_req;
    bus.h_we    = s.h_we;
    bus.h_addr  = s.h_addr;
    bus.h_wdata = s.h_wdata;
    #1;
    model_out = modelExpect(s);
    modelUpdate(s, model_out);
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act = sampleOut();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got cg=%b hg=%b stall=%b we=%b addr=%h wd=%h crv=%b crd=%h hrv=%b hrd=%h; expected cg=%b hg=%b stall=%b we=%b addr=%h wd=%h crv=%b crd=%h hrv=%b hrd=%h",
               name, act.c_gnt, act.h_gnt, act.stall, act.mem_we, act.mem_addr, act.mem_wdata,
               act.c_rvalid, act.c_rdata, act.h_rvalid, act.h_rdata,
               exp.c_gnt, exp.h_gnt, exp.stall, exp.mem_we, exp.mem_addr, exp.mem_wdata,
               exp.c_rvalid, exp.c_rdata, exp.h_rvalid, exp.h_rdata);
    end
  endtask

  task automatic checkGrant(input string name, input logic exp_c, input logic exp_h);
    tests++;
    if (bus.c_gnt !== exp_c || bus.h_gnt !== exp_h) begin
      fails++;
      $display("[TB] FAIL %s: got c_gnt=%b h_gnt=%b; expected c_gnt=%b h_gnt=%b",
               name, bus.c_gnt, bus.h_gnt, exp_c, exp_h);
    end
  endtask

  initial begin
    in_t idle;
    in_t both;
    in_t r;

    reset       = 1'b0;
    bus.c_req   = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.h_req   = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
    for (int i = 0; i < 256; i++) ref_ram[i] = 16'(i * 7 + 3);

    idle = mkIn(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    both = mkIn(1, 1, 0, 16'h4, 16'h0, 1, 0, 16'h5, 16'h0);

    // Directed vectors. RAM starts as ram[i] = 7*i + 3.
    addVec(mkIn(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0), mkOut(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 16'h0));
    addVec(mkIn(0, 1, 0, 16'h5, 16'h0, 0, 0, 16'h0, 16'h0), mkOut(0, 0, 1, 0, 16'h0, 16'h0, 0, 16'h0, 0, 16'h0));
    addVec(mkIn(1, 1, 0, 16'h1, 16'h1234, 0, 0, 16'h0, 16'h0), mkOut(1, 0, 0, 0, 16'h1, 16'h1234, 0, 16'h0, 0, 16'h0));
    addVec(idle, mkOut(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h000A, 0, 16'h0));
    addVec(mkIn(1, 0, 0, 16'h0, 16'h0, 1, 1, 16'h3F, 16'h0), mkOut(0, 1, 0, 1, 16'h3F, 16'h0, 0, 16'h0, 0, 16'h0));
    addVec(idle, mkOut(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 16'h0));
    addVec(mkIn(1, 1, 0, 16'h2, 16'h0, 0, 0, 16'h0, 16'h0), mkOut(1, 0, 0, 0, 16'h2, 16'h0, 0, 16'h0, 0, 16'h0));
    addVec(mkIn(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h3, 16'h0), mkOut(0, 1, 0, 0, 16'h3, 16'h0, 1, 16'h0011, 0, 16'h0));
    addVec(idle, mkOut(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 1, 16'h0018));
    addVec(mkIn(1, 1, 1, 16'h10, 16'hBEEF, 0, 0, 16'h0, 16'h0), mkOut(1, 0, 0, 1, 16'h10, 16'hBEEF, 0, 16'h0, 0, 16'h0));
    addVec(mkIn(1, 1, 0, 16'h10, 16'h0, 0, 0, 16'h0, 16'h0), mkOut(1, 0, 0, 0, 16'h10, 16'h0, 0, 16'h0, 0, 16'h0));
    addVec(idle, mkOut(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'hBEEF, 0, 16'h0));
    addVec(mkIn(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h3F, 16'h5555), mkOut(0, 1, 0, 0, 16'h3F, 16'h5555, 0, 16'h0, 0, 16'h0));
    addVec(idle, mkOut(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 1, 16'h0000));
    // Six contended cycles: CPU four times, host forced on the fifth.
    addVec(both, mkOut(1, 0, 0, 0, 16'h4, 16'h0, 0, 16'h0, 0, 16'h0));
    addVec(both, mkOut(1, 0, 0, 0, 16'h4, 16'h0, 1, 16'h001F, 0, 16'h0));
    addVec(both, mkOut(1, 0, 0, 0, 16'h4, 16'h0, 1, 16'h001F, 0, 16'h0));
    addVec(both, mkOut(1, 0, 0, 0, 16'h4, 16'h0, 1, 16'h001F, 0, 16'h0));
    addVec(both, mkOut(0, 1, 1, 0, 16'h5, 16'h0, 1, 16'h001F, 0, 16'h0));
    addVec(both, mkOut(1, 0, 0, 0, 16'h4, 16'h0, 0, 16'h0, 1, 16'h0026));
    addVec(idle, mkOut(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h001F, 0, 16'h0));
    // Read accepted, then reset: no return, and arbitration resumes at once.
    addVec(mkIn(1, 1, 0, 16'h6, 16'h0, 0, 0, 16'h0, 16'h0), mkOut(1, 0, 0, 0, 16'h6, 16'h0, 0, 16'h0, 0, 16'h0));
    addVec(mkIn(0, 1, 0, 16'h6, 16'h0, 0, 0, 16'h0, 16'h0), mkOut(0, 0, 1, 0, 16'h0, 16'h0, 0, 16'h0, 0, 16'h0));
    addVec(mkIn(1, 1, 0, 16'h6, 16'h0, 0, 0, 16'h0, 16'h0), mkOut(1, 0, 0, 0, 16'h6, 16'h0, 0, 16'h0, 0, 16'h0));
    addVec(idle, mkOut(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h002D, 0, 16'h0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Ten idle cycles: the RAM sees nothing and nobody is stalled.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(idle);
      checkOutput($sformatf("idle%0d", i), '0);
    end

    // Reset must clear a partly built-up host wait count.
    both = mkIn(1, 1, 0, 16'h8, 16'h0, 1, 0, 16'h9, 16'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(both);
      checkGrant($sformatf("prewait%0d", i), 1'b1, 1'b0);
    end
    r = both;
    r.rst = 1'b0;
    applyStimulus(r);
    checkGrant("wait_reset", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(both);
      checkGrant($sformatf("postrst%0d", i), (i != 4), (i == 4));
    end

    // Dropping the host request for a cycle also restarts the count.
    applyStimulus(both);
    checkGrant("after_force", 1'b1, 1'b0);
    r = both;
    r.h_req = 1'b0;
    applyStimulus(r);
    checkGrant("host_drop", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(both);
      checkGrant($sformatf("postdrop%0d", i), (i != 4), (i == 4));
    end

    // Randomized traffic against the reference model.
    r = idle;
    r.rst = 1'b0;
    applyStimulus(r);
    checkOutput("rand_reset", model_out);
    for (int n = 0; n < 600; n++) begin
      r.rst     = ($urandom_range(0, 31) != 0);
      r.c_req   = ($urandom_range(0, 9) < 7);
      r.c_we    = ($urandom_range(0, 2) == 0);
      r.c_addr  = 16'($urandom_range(0, 255));
      r.c_wdata = 16'($urandom);
      r.h_req   = ($urandom_range(0, 1) == 1);
      r.h_we    = ($urandom_range(0, 2) == 0);
      r.h_addr  = 16'($urandom_range(0, 255));
      r.h_wdata = 16'($urandom);
      applyStimulus(r);
      checkOutput($sformatf("rand%0d", n), model_out);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, meaning address width.
REQ-002 SHALL have parameter DW, default 16, meaning data width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, meaning host cycles lost before a forced host grant; range 1..15.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports c_req/c_we  input  1 each  CPU access request / write enable.
REQ-007 SHALL have ports c_addr  input  AW; c_wdata  input  DW  CPU address / write data.
REQ-008 SHALL have ports c_gnt  output  1; stall  output  1  CPU access accepted this cycle / CPU must hold PC and instruction.
REQ-009 SHALL have ports c_rvalid  output  1; c_rdata  output  DW  CPU read data return.
REQ-010 SHALL have ports h_req/h_we  input  1; h_addr  input  AW; h_wdata  input  DW  host (loader/debug) request.
REQ-011 SHALL have ports h_gnt, h_rvalid  output  1; h_rdata  output  DW  host grant / read return.
REQ-012 SHALL have ports mem_we  output  1; mem_addr  output  AW; mem_wdata  output  DW; mem_rdata  input  DW  single-port data RAM; synchronous read, data valid the cycle after the address.

Function
REQ-013 SHALL accept at most one access per cycle; an access is accepted in a cycle where req && gnt for that port.
REQ-014 SHALL compute c_gnt/h_gnt combinationally from current req inputs and the wait counter; gnt never asserted without req.
REQ-015 SHALL grant the sole requester when only one of c_req/h_req is high.
REQ-016 SHALL, when both request, grant CPU unless wait_cnt == MAX_WAIT, in which case grant host.
REQ-017 SHALL maintain wait_cnt: increment when h_req && !h_gnt, saturate at MAX_WAIT, clear to 0 on h_gnt or !h_req.
REQ-018 SHALL drive stall = c_req && !c_gnt, combinationally.
REQ-019 SHALL drive mem_addr/mem_wdata/mem_we combinationally from the granted port; mem_we = granted port's we; with no grant mem_we = 0 and mem_addr/mem_wdata = 0.
REQ-020 SHALL, for an accepted read, pulse the issuing port's rvalid for exactly one cycle, the cycle after acceptance, with rdata = mem_rdata in that cycle.
REQ-021 SHALL NOT assert rvalid for writes; writes complete in the accept cycle.
REQ-022 SHALL hold rdata at 0 when the corresponding rvalid is low.
REQ-023 SHALL support back-to-back accepts every cycle, alternating ports allowed, with each rvalid routed to its own issuer (1-bit owner register + 1-bit read-pending register).
REQ-024 SHALL keep a held request unchanged semantics: requester holds req/addr/data until gnt; arbiter does not latch ungranted requests.

Reset
REQ-025 SHALL, while reset == 0 at a rising edge, clear wait_cnt, read-pending and owner; reset has priority over all other updates.
REQ-026 SHALL force c_gnt, h_gnt, mem_we, c_rvalid, h_rvalid to 0 and stall to c_req while reset is low; a read accepted the cycle before reset asserts returns no rvalid.
REQ-027 SHALL begin arbitration in the first cycle with reset == 1.

Structure
REQ-028 SHALL place the port-select enum (PORT_CPU, PORT_HOST) and the default AW/DW/MAX_WAIT constants in a shared package, dmem_pkg.
REQ-029 SHALL implement the grant/fairness logic as one sub-module, rr_fair_sel (inputs two reqs, outputs two gnts, owns wait_cnt); the rest stays in dmem_arbiter.

Verification
REQ-030 CPU-only read: c_req=1, c_we=0, c_addr=0x0001, RAM[1]=0x000A -> c_gnt=1, stall=0, next cycle c_rvalid=1, c_rdata=0x000A.
REQ-031 Host-only write: h_req=1, h_we=1, h_addr=0x003F, h_wdata=0x0000 -> h_gnt=1, mem_we=1, mem_addr=0x003F same cycle; no h_rvalid.
REQ-032 Contention: c_req and h_req held high 6 cycles, MAX_WAIT=4 -> c_gnt cycles 1-4, h_gnt cycle 5 with stall=1, c_gnt cycle 6, wait_cnt back to 0.
REQ-033 Alternating reads: CPU read 0x0002 cycle 1, host read 0x0003 cycle 2 -> c_rvalid only in cycle 2, h_rvalid only in cycle 3, data from matching addresses.
REQ-034 Reset mid-read: CPU read accepted, reset=0 next edge -> no c_rvalid, all grants 0, wait_cnt=0; after release CPU read granted first cycle.
REQ-035 Idle: no requests -> mem_we=0, mem_addr=0, gnts 0, stall=0 for 10 cycles.
